// File: rtl/diff_rx_deserializer_if.sv
// rtl/diff_rx_deserializer_if.sv - serial input and aligned word output bundle for diff_rx_deserializer
interface diff_rx_deserializer_if #(
  parameter int WIDTH = 8
);
  logic                       D;
  logic                       EN;
  logic                       ALIGN_REQ;
  logic [WIDTH-1:0]           DATA_OUT;
  logic                       DATA_VALID;
  logic                       LOCKED;
  logic [$clog2(WIDTH)-1:0]   BITSLIP_CNT;
  logic                       ALIGN_ERR;

  modport master (
    output D, EN, ALIGN_REQ,
    input  DATA_OUT, DATA_VALID, LOCKED, BITSLIP_CNT, ALIGN_ERR
  );

  modport slave (
    input  D, EN, ALIGN_REQ,
    output DATA_OUT, DATA_VALID, LOCKED, BITSLIP_CNT, ALIGN_ERR
  );
endinterface

// File: rtl/diff_rx_deserializer.sv
// rtl/diff_rx_deserializer.sv - serial-to-parallel receiver with bit-slip word alignment
module diff_rx_deserializer #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(8'hA5),
  parameter int               MATCH_COUNT   = 4
) (
  input logic                C,
  input logic                R,
  diff_rx_deserializer_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int TW = $clog2(2 * WIDTH + 1);
  localparam int MW = 4;
  localparam logic [TW-1:0] TRIES_MAX = TW'(2 * WIDTH);
  localparam logic [SW-1:0] BCNT_LAST = SW'(WIDTH - 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

  state_t           state;
  // sr[0] would be shifted out on the next bit, so only the upper bits are kept
  logic [WIDTH-1:1] sr;
  logic [SW-1:0]    bcnt;
  logic [SW-1:0]    slip_cnt;
  logic [MW-1:0]    mcnt;
  logic [TW-1:0]    tries;
  logic             slip_pend;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             locked;
  logic             align_err;

  logic [WIDTH-1:0] word;
  logic             boundary;
  logic             match;
  logic             do_slip;

  always_comb begin
    word     = {bus.D, sr[WIDTH-1:1]};
    boundary = bus.EN && !slip_pend && (bcnt == BCNT_LAST);
    match    = (word == TRAIN_PATTERN);
    do_slip  = boundary && !bus.ALIGN_REQ && !match && (state != LOCK);
  end

  always_ff @(posedge C) begin
    if (R) begin
      state      <= HUNT;
      sr         <= '0;
      bcnt       <= '0;
      slip_cnt   <= '0;
      mcnt       <= '0;
      tries      <= '0;
      slip_pend  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (bus.EN) begin
        sr <= word[WIDTH-1:1];
        if (slip_pend) begin
          bcnt      <= '0;
          slip_pend <= 1'b0;
        end else if (boundary) begin
          bcnt <= '0;
        end else begin
          bcnt <= bcnt + SW'(1);
        end
        if (boundary) begin
          data_out <= word;
        end
      end

      if (bus.ALIGN_REQ) begin
        state     <= HUNT;
        locked    <= 1'b0;
        mcnt      <= '0;
        tries     <= '0;
        align_err <= 1'b0;
        slip_pend <= 1'b0;
      end else if (boundary) begin
        case (state)
          HUNT: begin
            if (match) begin
              tries <= '0;
              if (MATCH_COUNT == 1) begin
                state      <= LOCK;
                locked     <= 1'b1;
                data_valid <= 1'b1;
              end else begin
                state <= VERIFY;
                mcnt  <= MW'(1);
              end
            end
          end
          VERIFY: begin
            if (match) begin
              mcnt <= mcnt + MW'(1);
              if ((mcnt + MW'(1)) == MW'(MATCH_COUNT)) begin
                state      <= LOCK;
                locked     <= 1'b1;
                data_valid <= 1'b1;
              end
            end else begin
              state <= HUNT;
              mcnt  <= '0;
            end
          end
          LOCK: begin
            data_valid <= 1'b1;
          end
          default: begin
            state <= HUNT;
          end
        endcase
      end

      // A mismatch in HUNT or VERIFY shifts the word window one bit later
      if (do_slip) begin
        slip_pend <= 1'b1;
        slip_cnt  <= (slip_cnt == BCNT_LAST) ? '0 : slip_cnt + SW'(1);
        if (tries != TRIES_MAX) begin
          tries <= tries + TW'(1);
        end
        if ((tries + TW'(1)) >= TRIES_MAX) begin
          align_err <= 1'b1;
        end
      end
    end
  end

  assign bus.DATA_OUT    = data_out;
  assign bus.DATA_VALID  = data_valid;
  assign bus.LOCKED      = locked;
  assign bus.BITSLIP_CNT = slip_cnt;
  assign bus.ALIGN_ERR   = align_err;
endmodule

// File: tb/tb_diff_rx_deserializer.sv
// tb/tb_diff_rx_deserializer.sv - directed self-checking bench for diff_rx_deserializer
module tb_diff_rx_deserializer;
  localparam int W = 8;

  logic C = 1'b0;
  logic R = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] pat = 8'hA5;

  always #5 C = ~C;

  diff_rx_deserializer_if #(.WIDTH(W)) bus ();

  diff_rx_deserializer #(
    .WIDTH(W),
    .TRAIN_PATTERN(8'hA5),
    .MATCH_COUNT(4)
  ) dut (
    .C(C),
    .R(R),
    .bus(bus)
  );

  task automatic tick(input logic d, input logic en, input logic areq);
    bus.D = d;
    bus.EN = en;
    bus.ALIGN_REQ = areq;
    @(posedge C);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    R = 1'b0;
  endtask

  task automatic test_reset();
    R = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(i[0], 1'b1, 1'b0);
      n_checks++;
      if (bus.DATA_OUT !== 8'h00) begin
        n_fail++; $display("FAIL reset_data_out cycle %0d: got %h want 00", i, bus.DATA_OUT);
      end
      n_checks++;
      if (bus.DATA_VALID !== 1'b0) begin
        n_fail++; $display("FAIL reset_data_valid cycle %0d: got %b want 0", i, bus.DATA_VALID);
      end
      n_checks++;
      if (bus.LOCKED !== 1'b0) begin
        n_fail++; $display("FAIL reset_locked cycle %0d: got %b want 0", i, bus.LOCKED);
      end
      n_checks++;
      if (bus.BITSLIP_CNT !== 3'd0) begin
        n_fail++; $display("FAIL reset_bitslip cycle %0d: got %0d want 0", i, bus.BITSLIP_CNT);
      end
      n_checks++;
      if (bus.ALIGN_ERR !== 1'b0) begin
        n_fail++; $display("FAIL reset_align_err cycle %0d: got %b want 0", i, bus.ALIGN_ERR);
      end
    end
    R = 1'b0;
  endtask

  task automatic test_aligned_lock();
    logic exp_lock, exp_dv;
    do_reset();
    for (int e = 1; e <= 48; e++) begin
      tick(pat[(e - 1) % 8], 1'b1, 1'b0);
      exp_lock = (e >= 32);
      exp_dv = (e >= 32) && (e % 8 == 0);
      n_checks++;
      if (bus.LOCKED !== exp_lock) begin
        n_fail++; $display("FAIL aligned_locked edge %0d: got %b want %b", e, bus.LOCKED, exp_lock);
      end
      n_checks++;
      if (bus.DATA_VALID !== exp_dv) begin
        n_fail++; $display("FAIL aligned_valid edge %0d: got %b want %b", e, bus.DATA_VALID, exp_dv);
      end
      if (e % 8 == 0) begin
        n_checks++;
        if (bus.DATA_OUT !== 8'hA5) begin
          n_fail++; $display("FAIL aligned_data edge %0d: got %h want a5", e, bus.DATA_OUT);
        end
        n_checks++;
        if (bus.BITSLIP_CNT !== 3'd0) begin
          n_fail++; $display("FAIL aligned_bitslip edge %0d: got %0d want 0", e, bus.BITSLIP_CNT);
        end
      end
    end
  endtask

  task automatic test_misaligned_lock();
    logic exp_lock;
    do_reset();
    for (int e = 1; e <= 70; e++) begin
      tick(pat[(e + 4) % 8], 1'b1, 1'b0);
      exp_lock = (e >= 59);
      n_checks++;
      if (bus.LOCKED !== exp_lock) begin
        n_fail++; $display("FAIL misaligned_locked edge %0d: got %b want %b", e, bus.LOCKED, exp_lock);
      end
      if (e == 17) begin
        n_checks++;
        if (bus.BITSLIP_CNT !== 3'd2) begin
          n_fail++; $display("FAIL misaligned_bitslip_2 edge %0d: got %0d want 2", e, bus.BITSLIP_CNT);
        end
      end
      if (e == 26) begin
        n_checks++;
        if (bus.BITSLIP_CNT !== 3'd3) begin
          n_fail++; $display("FAIL misaligned_bitslip_3 edge %0d: got %0d want 3", e, bus.BITSLIP_CNT);
        end
      end
      if (e == 59) begin
        n_checks++;
        if (bus.DATA_VALID !== 1'b1) begin
          n_fail++; $display("FAIL misaligned_valid edge %0d: got %b want 1", e, bus.DATA_VALID);
        end
        n_checks++;
        if (bus.DATA_OUT !== 8'hA5) begin
          n_fail++; $display("FAIL misaligned_data edge %0d: got %h want a5", e, bus.DATA_OUT);
        end
        n_checks++;
        if (bus.BITSLIP_CNT !== 3'd3) begin
          n_fail++; $display("FAIL misaligned_bitslip_lock edge %0d: got %0d want 3", e, bus.BITSLIP_CNT);
        end
      end
    end
  endtask

  task automatic test_verify_failure();
    logic [7:0] bad = 8'hA4;
    logic d;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      if (e <= 8) d = pat[e - 1];
      else if (e <= 16) d = bad[e - 9];
      else d = 1'b0;
      tick(d, 1'b1, 1'b0);
      n_checks++;
      if (bus.DATA_VALID !== 1'b0 || bus.LOCKED !== 1'b0) begin
        n_fail++; $display("FAIL verify_no_lock edge %0d: got valid=%b locked=%b want 0/0", e, bus.DATA_VALID, bus.LOCKED);
      end
      if (e == 8 || e == 24) begin
        n_checks++;
        if (bus.BITSLIP_CNT !== ((e == 8) ? 3'd0 : 3'd1)) begin
          n_fail++; $display("FAIL verify_bitslip edge %0d: got %0d want %0d", e, bus.BITSLIP_CNT, (e == 8) ? 0 : 1);
        end
      end
      if (e == 16) begin
        n_checks++;
        if (bus.DATA_OUT !== 8'hA4) begin
          n_fail++; $display("FAIL verify_bad_word edge %0d: got %h want a4", e, bus.DATA_OUT);
        end
        n_checks++;
        if (bus.BITSLIP_CNT !== 3'd1) begin
          n_fail++; $display("FAIL verify_slip edge %0d: got %0d want 1", e, bus.BITSLIP_CNT);
        end
      end
      if (e == 25) begin
        n_checks++;
        if (bus.BITSLIP_CNT !== 3'd2) begin
          n_fail++; $display("FAIL verify_resume edge %0d: got %0d want 2", e, bus.BITSLIP_CNT);
        end
        n_checks++;
        if (bus.DATA_OUT !== 8'h00) begin
          n_fail++; $display("FAIL verify_resume_data edge %0d: got %h want 00", e, bus.DATA_OUT);
        end
      end
    end
  endtask

  task automatic test_no_lock();
    int nb = 0;
    logic [2:0] exp_slip;
    logic exp_err;
    do_reset();
    for (int e = 1; e <= 160; e++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (e == 8 || (e > 8 && (e - 8) % 9 == 0)) nb++;
      exp_slip = 3'(nb % 8);
      exp_err = (nb >= 16);
      n_checks++;
      if (bus.BITSLIP_CNT !== exp_slip) begin
        n_fail++; $display("FAIL nolock_bitslip edge %0d: got %0d want %0d", e, bus.BITSLIP_CNT, exp_slip);
      end
      n_checks++;
      if (bus.ALIGN_ERR !== exp_err) begin
        n_fail++; $display("FAIL nolock_align_err edge %0d: got %b want %b", e, bus.ALIGN_ERR, exp_err);
      end
    end
    tick(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.ALIGN_ERR !== 1'b0) begin
      n_fail++; $display("FAIL nolock_err_clear: got %b want 0", bus.ALIGN_ERR);
    end
    n_checks++;
    if (bus.BITSLIP_CNT !== 3'd1) begin
      n_fail++; $display("FAIL nolock_bitslip_kept: got %0d want 1", bus.BITSLIP_CNT);
    end
  endtask

  task automatic test_realign();
    logic exp_lock, exp_dv;
    do_reset();
    for (int e = 1; e <= 96; e++) begin
      tick(pat[(e - 1) % 8], 1'b1, (e == 56));
      exp_lock = (e >= 32 && e < 56) || (e >= 88);
      exp_dv = exp_lock && (e % 8 == 0);
      n_checks++;
      if (bus.LOCKED !== exp_lock) begin
        n_fail++; $display("FAIL realign_locked edge %0d: got %b want %b", e, bus.LOCKED, exp_lock);
      end
      n_checks++;
      if (bus.DATA_VALID !== exp_dv) begin
        n_fail++; $display("FAIL realign_valid edge %0d: got %b want %b", e, bus.DATA_VALID, exp_dv);
      end
      if (e == 56) begin
        n_checks++;
        if (bus.DATA_OUT !== 8'hA5) begin
          n_fail++; $display("FAIL realign_data edge %0d: got %h want a5", e, bus.DATA_OUT);
        end
      end
    end
  endtask

  task automatic test_en_gap();
    logic [7:0] gw = 8'h3C;
    logic [15:0] bb = 16'hC35A;
    logic en, d, exp_dv;
    int bi = 0;
    do_reset();
    for (int e = 1; e <= 32; e++) tick(pat[(e - 1) % 8], 1'b1, 1'b0);
    n_checks++;
    if (bus.LOCKED !== 1'b1) begin
      n_fail++; $display("FAIL gap_precondition_locked: got %b want 1", bus.LOCKED);
    end
    for (int k = 0; k < 13; k++) begin
      en = !(k >= 3 && k <= 7);
      d = en ? gw[bi] : k[0];
      if (en) bi++;
      tick(d, en, 1'b0);
      exp_dv = (k == 12);
      n_checks++;
      if (bus.DATA_VALID !== exp_dv) begin
        n_fail++; $display("FAIL gap_valid tick %0d: got %b want %b", k, bus.DATA_VALID, exp_dv);
      end
    end
    n_checks++;
    if (bus.DATA_OUT !== 8'h3C) begin
      n_fail++; $display("FAIL gap_data: got %h want 3c", bus.DATA_OUT);
    end
    for (int k = 0; k < 16; k++) begin
      tick(bb[k], 1'b1, 1'b0);
      exp_dv = (k % 8 == 7);
      n_checks++;
      if (bus.DATA_VALID !== exp_dv) begin
        n_fail++; $display("FAIL b2b_valid tick %0d: got %b want %b", k, bus.DATA_VALID, exp_dv);
      end
      if (k == 7 || k == 15) begin
        n_checks++;
        if (bus.DATA_OUT !== ((k == 7) ? 8'h5A : 8'hC3)) begin
          n_fail++; $display("FAIL b2b_data tick %0d: got %h want %h", k, bus.DATA_OUT, (k == 7) ? 8'h5A : 8'hC3);
        end
      end
    end
  endtask

  initial begin
    bus.D = 1'b0;
    bus.EN = 1'b0;
    bus.ALIGN_REQ = 1'b0;
    test_reset();
    test_aligned_lock();
    test_misaligned_lock();
    test_verify_failure();
    test_no_lock();
    test_realign();
    test_en_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/diff_rx_deserializer.md
# diff_rx_deserializer

Serial-to-parallel receive stage sitting directly downstream of a differential input buffer (I_BUF_DS output, already single-ended and registered into the core clock domain). It shifts in one bit per enabled clock, finds word alignment against a fixed training pattern using a bit-slip search, and presents aligned parallel words with a one-cycle valid strobe once locked.

## Interface
- WIDTH, 8: parallel word width in bits. Legal range is 4 to 16.
- TRAIN_PATTERN, 8'hA5: training word, WIDTH bits wide. All its rotations must differ from it.
- MATCH_COUNT, 4: consecutive matching words required to declare lock. Legal range is 1 to 15.
- C  input  1  clock; every register updates on the rising edge.
- R  input  1  reset; synchronous, active-high.
- D  input  1  serial data from the differential input buffer; sampled on C when EN=1.
- EN  input  1  bit enable; when 0, no shift, no counter advance, no state change except R and ALIGN_REQ.
- ALIGN_REQ  input  1  single-cycle request to restart the alignment search.
- DATA_OUT  output  WIDTH  last completed word; D's first-received bit lands in bit 0.
- DATA_VALID  output  1  one-cycle pulse: DATA_OUT holds a new word and the block is LOCKED.
- LOCKED  output  1  high in the LOCKED state.
- BITSLIP_CNT  output  $clog2(WIDTH)  cumulative slips applied, modulo WIDTH.
- ALIGN_ERR  output  1  sticky flag: 2*WIDTH consecutive slips have occurred without a pattern match.

## Operation
- Shift register `sr` (WIDTH bits). On each EN cycle: sr <= {D, sr[WIDTH-1:1]}.
- Bit counter `bcnt` runs 0..WIDTH-1.
  - An EN cycle with bcnt==WIDTH-1 is a **boundary**. The word is {D, sr[WIDTH-1:1]}, and bcnt wraps to 0.
  - A pending slip makes the next EN cycle shift normally while holding bcnt at 0. This moves the window one bit later.
- At every boundary, DATA_OUT is loaded with the word in all states.
- FSM states are HUNT, VERIFY and LOCKED. Reset state is HUNT.
- **HUNT**, at each boundary:
  - word==TRAIN_PATTERN: go to VERIFY with mcnt=1. If MATCH_COUNT==1, go straight to LOCKED instead.
  - Otherwise: set slip pending, BITSLIP_CNT += 1 (mod WIDTH), tries += 1.
  - When tries reaches 2*WIDTH, set ALIGN_ERR. The search continues with tries saturating.
- **VERIFY**, at each boundary:
  - Match: mcnt += 1. When mcnt reaches MATCH_COUNT, go to LOCKED.
  - Mismatch: go to HUNT, clear mcnt, and slip exactly as in HUNT.
- **LOCKED**:
  - LOCKED=1. Every boundary pulses DATA_VALID regardless of the word's content.
  - The block stays LOCKED until ALIGN_REQ or R.
- **ALIGN_REQ** (any state):
  - Next state is HUNT. mcnt, tries, ALIGN_ERR and any pending slip are cleared.
  - BITSLIP_CNT and bcnt are retained.
  - ALIGN_REQ takes priority over a simultaneous boundary. DATA_OUT still loads, but DATA_VALID stays 0 and no match is evaluated.
- **R** takes priority over everything.
  - Reset values: sr=0, bcnt=0, mcnt=0, tries=0, state=HUNT, DATA_OUT=0, DATA_VALID=0, LOCKED=0, BITSLIP_CNT=0, ALIGN_ERR=0.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- DATA_OUT and DATA_VALID change on the same edge that samples the WIDTH-th bit of a word.
- DATA_VALID is high for exactly one cycle per boundary while LOCKED. It is never high on consecutive cycles when WIDTH>1.
- LOCKED rises on the edge of the MATCH_COUNT-th consecutive matching boundary. DATA_VALID is also high on that edge.
- LOCKED falls on the edge that samples ALIGN_REQ=1 or R=1.
- A slip decided at boundary N takes effect on the first EN cycle after it. The next boundary comes WIDTH+1 EN cycles after boundary N.
- EN low mid-word stretches the word. Bits are never lost or duplicated.

## Test plan
- **Reset values:** hold R=1 for 3 cycles with D toggling → every output is 0 and no DATA_VALID appears.
- **Aligned lock:** with default parameters, send repeating 8'hA5 LSB-first starting at the first EN cycle after reset → LOCKED rises at the 4th boundary (32nd EN edge), BITSLIP_CNT=0, and DATA_VALID pulses every 8 cycles with DATA_OUT=8'hA5.
- **Misaligned lock:** same stream but the pattern phase starts 3 bits late → 3 slips occur, then lock with BITSLIP_CNT=3 and DATA_OUT=8'hA5.
- **VERIFY failure:** the pattern matches once, then a corrupted word (8'hA4) arrives → return to HUNT, BITSLIP_CNT increments by 1, and the search resumes.
- **No lock:** constant D=0 → BITSLIP_CNT wraps 7→0, ALIGN_ERR rises at the 16th mismatching boundary, and a subsequent ALIGN_REQ clears it.
- **Realign while locked:** assert ALIGN_REQ on a boundary cycle, and separately toggle EN low for 5 cycles mid-word → no DATA_VALID on the ALIGN_REQ boundary and LOCKED=0 the next cycle; the EN gap delays the word by 5 cycles with data intact.
